pt_write_port: RTL

Memory-side responder for the projective-transform pixel write interface (pt_wr / pt_x / pt_y / pt_pixel_write / ptflag). Accepts transformed pixels and clips out-of-frame coordinates. Buffers accepted pixels in a small FIFO and issues them as pipelined ZBT SRAM half-word writes into a double-buffered frame store, whenever the memory arbiter grants a write slot. Sits inside memory_interface, alongside the display read path that owns the other arbitration slots.

---
 rtl/mem_pkg.sv | 17 +
 rtl/pt_fifo.sv | 34 +++
 rtl/pt_write_port.sv | 80 ++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared frame-store geometry, ZBT timing, lane constants and pixel entry type
package mem_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int ZBT_WR_LAT = 2;
  localparam int PIXEL_W = 18;
  localparam int MEM_ADDR_W = 19;
  localparam logic [3:0] BWE_LO = 4'b0011;
  localparam logic [3:0] BWE_HI = 4'b1100;
  typedef struct packed {
    logic bank;
    logic [8:0] y;
    logic [9:0] x;
    logic [PIXEL_W-1:0] pixel;
  } pt_entry_t;
  typedef enum logic {IDLE, ISSUE} issue_state_t;
endpackage

// File: rtl/pt_fifo.sv
// pt_fifo: show-ahead synchronous FIFO with occupancy count and same-cycle push/pop
module pt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 38
)(
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign rd = pop && count != '0;
  assign wr = push && (count < (AW+1)'(DEPTH) || rd);
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/pt_write_port.sv
// pt_write_port: clips and queues transformed pixels, issues them as ZBT half-word writes
module pt_write_port #(
  parameter int DEPTH = 8,
  parameter int H_ACTIVE = mem_pkg::H_ACTIVE,
  parameter int V_ACTIVE = mem_pkg::V_ACTIVE,
  parameter int WR_LAT = mem_pkg::ZBT_WR_LAT
)(
  input  logic clk,
  input  logic reset_n,
  input  logic pt_wr,
  input  logic [9:0] pt_x,
  input  logic [8:0] pt_y,
  input  logic [17:0] pt_pixel_write,
  output logic ptflag,
  input  logic frame_swap,
  input  logic mem_grant,
  output logic [18:0] mem_addr,
  output logic mem_we,
  output logic [3:0] mem_bwe,
  output logic [35:0] mem_wdata,
  output logic mem_wdata_oe,
  output logic bank,
  output logic overflow,
  output logic [15:0] clip_count
);
  import mem_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;
  pt_entry_t head, entry;
  issue_state_t state;
  logic [CW-1:0] count, next_count;
  logic in_range, want, pop, push;
  logic [WR_LAT-1:0] pv;
  logic [35:0] pd [WR_LAT];
  logic [35:0] wdata;
  assign in_range = pt_x < 10'(H_ACTIVE) && pt_y < 9'(V_ACTIVE);
  assign want = pt_wr && in_range;
  // reset_n gating makes a mid-burst reset silence the bus in the very cycle it is sampled
  assign pop = reset_n && state == ISSUE && mem_grant;
  assign push = want && (count < CW'(DEPTH) || pop);
  assign next_count = count + CW'(push) - CW'(pop);
  assign entry = '{bank: bank, y: pt_y, x: pt_x, pixel: pt_pixel_write};
  assign wdata = head.x[0] ? {head.pixel, 18'd0} : {18'd0, head.pixel};
  assign mem_we = pop;
  assign mem_addr = pop ? {head.bank, head.y, head.x[9:1]} : '0;
  assign mem_bwe = pop ? (head.x[0] ? BWE_HI : BWE_LO) : '0;
  assign mem_wdata = pd[WR_LAT-1];
  assign mem_wdata_oe = reset_n && pv[WR_LAT-1];
  pt_fifo #(.DEPTH(DEPTH), .WIDTH($bits(pt_entry_t))) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .push(push),
    .pop(pop),
    .din(entry),
    .dout(head),
    .count(count)
  );
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      ptflag <= 1'b0;
      bank <= 1'b0;
      overflow <= 1'b0;
      clip_count <= '0;
      pv <= '0;
      for (int i = 0; i < WR_LAT; i++) pd[i] <= '0;
    end else begin
      state <= next_count != '0 ? ISSUE : IDLE;
      ptflag <= next_count <= CW'(DEPTH - 2);
      bank <= bank ^ frame_swap;
      overflow <= overflow | (want && !push);
      if (pt_wr && !in_range && clip_count != 16'hFFFF) clip_count <= clip_count + 16'd1;
      pv[0] <= pop;
      pd[0] <= pop ? wdata : '0;
      for (int i = 1; i < WR_LAT; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end
endmodule
